// File: rtl/mux4_rr_scheduler.sv
// Round-robin owner of a shared mux_4_1 select path with minimum dwell and a one-cycle blank on every handover.
// Latency: request to grant is 1 cycle; handover is DWELL_CYCLES+1 cycles from grant start to the next grant.
// Backpressure: none; requesters hold req until granted, and lock lets the owner keep the grant past its dwell.

// Single-bit 4:1 mux that sits behind the scheduler; index = {s1,s0}.
module mux_4_1 (
    input  logic d0,
    input  logic d1,
    input  logic d2,
    input  logic d3,
    input  logic s1,
    input  logic s0,
    output logic y
);

    // Select one data bit from the registered select lines.
    always_comb begin
        y = d0;
        case ({s1, s0})
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end

endmodule

module mux4_rr_scheduler #(
    parameter int unsigned DWELL_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       lock,
    output logic       s1,
    output logic       s0,
    output logic [3:0] grant,
    output logic       valid
);

    localparam logic [7:0] DWELL_MAX = 8'(DWELL_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic       valid_q, valid_d;
    logic [1:0] sel_q,   sel_d;
    logic [1:0] last_q,  last_d;
    logic [7:0] dwell_cnt_q, dwell_cnt_d;

    logic       win_vld;
    logic [1:0] win_idx;
    logic [1:0] cand;
    logic       own_req;
    logic       other_req;
    logic       dwell_done;

    // Round-robin search: last+1, last+2, last+3, then last itself, so the
    // previous owner only wins again when nobody else is asking.
    always_comb begin
        win_vld = 1'b0;
        win_idx = last_q;
        cand    = last_q;
        for (int i = 1; i <= 4; i++) begin
            cand = last_q + 2'(i);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // The one-hot grant register identifies the owner while in GRANT.
    always_comb begin
        own_req    = |(req & grant_q);
        other_req  = |(req & ~grant_q);
        dwell_done = (dwell_cnt_q >= DWELL_MAX);
    end

    // Next-state and registered-output computation; select lines only move
    // when a new grant is taken, so they are stable whenever valid is high.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        valid_d     = valid_q;
        sel_d       = sel_q;
        last_d      = last_q;
        dwell_cnt_d = dwell_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d     = ST_GRANT;
                    grant_d     = 4'(1) << win_idx;
                    valid_d     = 1'b1;
                    sel_d       = win_idx;
                    last_d      = win_idx;
                    dwell_cnt_d = 8'd1;
                end
            end

            ST_GRANT: begin
                if (!dwell_done) begin
                    // Grant is held through the dwell even if the owner drops req.
                    dwell_cnt_d = dwell_cnt_q + 8'd1;
                end else if (!own_req || (other_req && !lock)) begin
                    state_d     = ST_SWITCH;
                    grant_d     = 4'b0000;
                    valid_d     = 1'b0;
                    dwell_cnt_d = 8'd0;
                end
                // Otherwise keep the grant with the counter left saturated.
            end

            ST_SWITCH: begin
                // Blank cycle: sel keeps the previous owner, lock is ignored.
                if (win_vld) begin
                    state_d     = ST_GRANT;
                    grant_d     = 4'(1) << win_idx;
                    valid_d     = 1'b1;
                    sel_d       = win_idx;
                    last_d      = win_idx;
                    dwell_cnt_d = 8'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                grant_d     = 4'b0000;
                valid_d     = 1'b0;
                dwell_cnt_d = 8'd0;
            end
        endcase
    end

    // State and output registers; last resets to 3 so the first search starts at 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= 4'b0000;
            valid_q     <= 1'b0;
            sel_q       <= 2'd0;
            last_q      <= 2'd3;
            dwell_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            valid_q     <= valid_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            dwell_cnt_q <= dwell_cnt_d;
        end
    end

    assign grant = grant_q;
    assign valid = valid_q;
    assign s1    = sel_q[1];
    assign s0    = sel_q[0];

endmodule

// File: tb/tb_mux4_rr_scheduler.sv
// Directed bench for mux4_rr_scheduler driving a mux_4_1 behind it.
// Expected per-cycle grant/valid/select values are queued with the stimulus and popped each cycle.
// Outputs are sampled 2 time units after each rising edge; inputs change right after sampling.
module tb_mux4_rr_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       lock;
    logic       s1;
    logic       s0;
    logic [3:0] grant;
    logic       valid;
    logic [3:0] d_vec;
    logic       y;

    typedef struct {
        logic [3:0] g;
        logic       v;
        logic [1:0] s;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks;
    int   n_fail;

    mux4_rr_scheduler #(.DWELL_CYCLES(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .lock  (lock),
        .s1    (s1),
        .s0    (s0),
        .grant (grant),
        .valid (valid)
    );

    mux_4_1 u_mux (
        .d0 (d_vec[0]),
        .d1 (d_vec[1]),
        .d2 (d_vec[2]),
        .d3 (d_vec[3]),
        .s1 (s1),
        .s0 (s0),
        .y  (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [3:0] g, input logic v, input logic [1:0] s, input int n);
        exp_t e;
        e.g = g;
        e.v = v;
        e.s = s;
        for (int i = 0; i < n; i++) sb_q.push_back(e);
    endtask

    // One clock: new mux data, then compare DUT outputs against the queue head.
    task automatic cyc();
        exp_t e;
        @(posedge clk);
        #1;
        d_vec = 4'($urandom_range(0, 15));
        #1;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL sb_empty: observed no expectation expected one queued");
        end else begin
            e = sb_q.pop_front();
            check("grant", grant, e.g);
            check("valid", {3'b0, valid}, {3'b0, e.v});
            check("sel", {2'b0, s1, s0}, {2'b0, e.s});
            if (e.v) check("mux_y", {3'b0, y}, {3'b0, d_vec[e.s]});
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        req      = 4'b0000;
        lock     = 1'b0;
        d_vec    = 4'b0000;

        // Reset state
        #3;
        check("rst_grant", grant, 4'b0000);
        check("rst_valid", {3'b0, valid}, 4'b0000);
        check("rst_sel", {2'b0, s1, s0}, 4'b0000);

        // Full rotation with all four requesting
        #9;
        rst = 1'b1;
        req = 4'b1111;
        for (int r = 0; r < 2; r++) begin
            for (int o = 0; o < 4; o++) begin
                push(4'(1) << o, 1'b1, 2'(o), 4);
                push(4'b0000, 1'b0, 2'(o), 1);
            end
        end
        run(40);
        req = 4'b0000;
        push(4'b0000, 1'b0, 2'd3, 1);
        run(1);

        // Lock is ignored with no owner
        lock = 1'b1;
        push(4'b0000, 1'b0, 2'd3, 2);
        run(2);

        // Lock: owner 0 keeps the grant past its dwell while 1 waits
        req = 4'b0011;
        push(4'b0001, 1'b1, 2'd0, 12);
        run(12);
        lock = 1'b0;
        push(4'b0000, 1'b0, 2'd0, 1);
        push(4'b0010, 1'b1, 2'd1, 1);
        run(2);
        req = 4'b0000;
        push(4'b0010, 1'b1, 2'd1, 3);
        push(4'b0000, 1'b0, 2'd1, 2);
        run(5);

        // Early release: one-cycle request still gets the full dwell
        req = 4'b0001;
        push(4'b0001, 1'b1, 2'd0, 1);
        run(1);
        req = 4'b0000;
        push(4'b0001, 1'b1, 2'd0, 3);
        push(4'b0000, 1'b0, 2'd0, 3);
        run(6);

        // Sole requester: one continuous grant, no blank cycles
        req = 4'b0100;
        push(4'b0100, 1'b1, 2'd2, 20);
        run(20);

        // Asynchronous reset mid-grant, between clock edges
        #1;
        rst = 1'b0;
        #1;
        check("arst_grant", grant, 4'b0000);
        check("arst_valid", {3'b0, valid}, 4'b0000);
        check("arst_sel", {2'b0, s1, s0}, 4'b0000);
        #1;
        rst = 1'b1;
        req = 4'b1111;
        push(4'b0001, 1'b1, 2'd0, 4);
        push(4'b0000, 1'b0, 2'd0, 1);
        push(4'b0010, 1'b1, 2'd1, 1);
        run(6);
        req = 4'b0000;

        n_checks++;
        assert (sb_q.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drain: observed %0d leftover expectations expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux4_rr_scheduler.md
# mux4_rr_scheduler

Round-robin scheduler that shares the single-bit `mux_4_1` output path among four requesters by driving its `s1`/`s0` select lines. Each grant holds for a configurable minimum dwell time, and every ownership change goes through a one-cycle blanking gap. The block sits directly in front of `mux_4_1` in the PWM generator datapath, one instance per shared mux.

## Interface
- `DWELL_CYCLES`, default 4: minimum number of cycles a grant is held (legal range 1..255).
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `req`  input  4  per-requester request; `req[i]` asks for mux input `d<i>`.
- `lock`  input  1  the current owner keeps the grant past its dwell while competitors wait.
- `s1`  output  1  mux select MSB; index = {s1,s0}.
- `s0`  output  1  mux select LSB.
- `grant`  output  4  one-hot grant; all zero when no owner.
- `valid`  output  1  high while the mux output belongs to the granted requester.

## Operation
- **State machine:** IDLE, GRANT, SWITCH.
- **Registered outputs:** all outputs are registered. `grant`, `valid` and {s1,s0} change only on a `clk` edge or on reset.
- **Round-robin pointer:** `last[1:0]` holds the index of the most recent owner.
  - Winner = first set `req` bit, searching `last+1`, `last+2`, `last+3`, `last` (mod 4, wraps 3→0).
- **Dwell counter:** `dwell_cnt` width is 8 bits.
  - Loaded with 1 on entering GRANT.
  - Increments each GRANT cycle and saturates at `DWELL_CYCLES`.
- **IDLE:**
  - `req==0`: stay.
  - Otherwise: go to GRANT with the winner. Set `grant` one-hot, {s1,s0} = winner, `valid`=1, `last` = winner.
- **GRANT, dwell in progress** (`dwell_cnt < DWELL_CYCLES`): stay; the grant is held even if `req[owner]` drops.
- **GRANT, dwell complete:**
  - `req[owner]==0`: go to SWITCH.
  - `req[owner]==1`, another `req` bit set, `lock==0`: go to SWITCH.
  - `req[owner]==1` with no competitors, or `lock==1`: stay in GRANT; the counter stays saturated.
- **SWITCH:** lasts exactly one cycle.
  - Outputs during SWITCH: `grant`=0, `valid`=0, {s1,s0} hold the previous owner's value.
  - Next state: if `req!=0`, GRANT to the winner found from the round-robin search; otherwise IDLE.
  - The previous owner wins again only if it is the sole requester.
- **Reset values** (reset asserted asynchronously): state=IDLE, `grant`=4'b0000, `valid`=0, `s1`=0, `s0`=0, `last`=2'd3 (so the first search starts at index 0), `dwell_cnt`=0.
- **Reset mid-grant:** outputs drop to reset values immediately, without waiting for a clock edge. The first grant after reset release goes to the lowest-indexed requester.

## Timing
- **Request to grant:** 1 cycle. `req` sampled high at edge N while in IDLE gives `grant`/`valid` high after edge N.
- **Grant duration:** a granted owner holds for at least `DWELL_CYCLES` cycles with `valid`=1.
- **Handover:** exactly 1 blank cycle (SWITCH) followed by the new grant. Handover latency is `DWELL_CYCLES`+1 cycles from grant start to the next owner's grant.
- **Glitch-free select:**
  - {s1,s0} never changes in a cycle where `valid`=1.
  - {s1,s0} changes only on entry to GRANT.
  - `mux_4_1` therefore sees a stable select whenever its output is qualified.
- **Simultaneous requests:** priority is resolved purely by the round-robin rotation. No requester waits more than 3 grants plus their SWITCH cycles, provided `lock` is not held indefinitely.
- **`lock` with no owner:** `lock` is ignored in IDLE and SWITCH.

## Test plan
- **Reset:** assert `rst`=0 mid-grant between clock edges → `grant`=0, `valid`=0, {s1,s0}=00 immediately. After release with `req`=4'b1111 → `grant`=4'b0001 one cycle later.
- **Full rotation:** `req`=4'b1111 constant, `DWELL_CYCLES`=4, `lock`=0 → grants 0001, 0010, 0100, 1000, 0001, … Each grant lasts 4 cycles with 1 blank cycle between; {s1,s0}=00,01,10,11.
- **Early release:** `req`=4'b0001 for 1 cycle only → grant to 0 held for 4 cycles, then SWITCH, then IDLE (`valid`=0, `grant`=0).
- **Lock:** `req`=4'b0011, `lock`=1 for 10 cycles after grant to 0 → owner 0 keeps the grant for 10+ cycles. `lock`→0 gives SWITCH and then `grant`=4'b0010.
- **Sole requester:** `req`=4'b0100 held for 20 cycles → single continuous grant 0100 with no SWITCH cycles, {s1,s0}=10.
- **End-to-end through the mux:** bench drives `d0..d3` to distinct patterns and connects `y` → `y` equals `d[{s1,s0}]` on every cycle with `valid`=1, and {s1,s0} is constant within each valid window.
